// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for generator and checker: x^8+x^6+x^5+x^4+1, Fibonacci form.
// Combinational helpers only; no latency, no backpressure.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;

  // Feedback is the XOR of bits 7,5,4,3, shifted in at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Single LFSR step, shared by generator and checker so both ends use one polynomial.
// Purely combinational; no backpressure.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] i_state,
  output logic [LFSR_W-1:0] o_next
);

  assign o_next = lfsr_next(i_state);

endmodule

// File: rtl/lfsr_seq_checker.sv
// LFSR stream checker: self-syncs (HUNT/VERIFY), then flywheels and counts word errors.
// Outputs registered, 1 cycle after the deciding word; no backpressure (data_valid only).
// Optional LFSR_SEQ_CHECKER_BITERR_EN adds a saturating bit-error accumulator.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_count
`ifdef LFSR_SEQ_CHECKER_BITERR_EN
  ,
  output logic [ERR_W-1:0] bit_err_count
`endif
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);

  chk_state_t       r_state;
  logic [WIDTH-1:0] r_expect;
  logic [GW-1:0]    r_good_cnt;
  logic [BW-1:0]    r_bad_cnt;
  logic             r_locked;
  logic             r_sync_lost;
  logic [ERR_W-1:0] r_err_count;

  logic [WIDTH-1:0] w_next_data;
  logic [WIDTH-1:0] w_next_exp;
  logic             w_match;
  logic             w_nonzero;
  logic             w_count_err;
  logic [ERR_W-1:0] w_err_base;
  logic [ERR_W-1:0] w_err_new;

  lfsr_step u_step_data (.i_state(data_in),  .o_next(w_next_data));
  lfsr_step u_step_exp  (.i_state(r_expect), .o_next(w_next_exp));

  assign w_match     = (data_in == r_expect);
  assign w_nonzero   = |data_in;
  assign w_count_err = data_valid && (r_state == LOCKED) && !w_match;

  // Clear is applied before the count so a same-cycle error lands on zero.
  always_comb begin
    w_err_base = clear_err ? '0 : r_err_count;
    w_err_new  = w_err_base;
    if (w_count_err && !(&w_err_base)) w_err_new = w_err_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_expect    <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_locked    <= 1'b0;
      r_sync_lost <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_sync_lost <= 1'b0;
      r_err_count <= w_err_new;
      if (data_valid) begin
        case (r_state)
          HUNT: begin
            if (w_nonzero) begin
              r_expect   <= w_next_data;
              r_good_cnt <= '0;
              r_state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_expect   <= w_next_data;
              r_good_cnt <= r_good_cnt + 1'b1;
              if (r_good_cnt == GW'(LOCK_COUNT - 1)) begin
                r_state   <= LOCKED;
                r_locked  <= 1'b1;
                r_bad_cnt <= '0;
              end
            end else if (w_nonzero) begin
              r_expect   <= w_next_data;
              r_good_cnt <= '0;
            end else begin
              r_state <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: expect advances from itself, never from the data.
            r_expect <= w_next_exp;
            if (w_match) begin
              r_bad_cnt <= '0;
            end else begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
              if (r_bad_cnt == BW'(UNLOCK_COUNT - 1)) begin
                r_state     <= HUNT;
                r_locked    <= 1'b0;
                r_sync_lost <= 1'b1;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign sync_lost = r_sync_lost;
  assign err_count = r_err_count;

`ifdef LFSR_SEQ_CHECKER_BITERR_EN
  localparam int SW = ((ERR_W > 4) ? ERR_W : 4) + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [ERR_W-1:0] r_bit_err;
  logic [ERR_W-1:0] w_bit_base;
  logic [SW-1:0]    w_pop;
  logic [SW-1:0]    w_bit_sum;
  logic [ERR_W-1:0] w_bit_new;

  always_comb begin
    w_bit_base = clear_err ? '0 : r_bit_err;
    w_pop      = SW'($countones(data_in ^ r_expect));
    w_bit_sum  = SW'(w_bit_base) + w_pop;
    w_bit_new  = w_bit_base;
    if (w_count_err) w_bit_new = (w_bit_sum > SW'(ERR_MAX)) ? ERR_MAX : w_bit_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_bit_err <= '0;
    else     r_bit_err <= w_bit_new;
  end

  assign bit_err_count = r_bit_err;
`endif

endmodule
